music_beat_ctrl: RTL and testbench
==================================

MUSIC_BEAT_CTRL -- requirements
Module: music_beat_ctrl

Interface
REQ-001 Parameter BEAT_DIV, default 32'd12_500_000, clock cycles per 1/4 beat (legal range >= 2).
REQ-002 Parameter LAST_BEAT, default 8'd255, final beat index of the song.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 play  input  1  one-cycle pulse: start, or resume from PAUSE.
REQ-006 pause_tgl  input  1  one-cycle pulse: toggle PLAY/PAUSE.
REQ-007 stop  input  1  one-cycle pulse: abort to IDLE.
REQ-008 loop_en  input  1  level: 1 = restart song after LAST_BEAT.
REQ-009 key_active  input  1  level: a piano key owns the tone path; song mutes and freezes.
REQ-010 beat_num  output  8  current 1/4-beat index, drives the song ROM beat input.
REQ-011 en_b  output  1  song enable to the song ROM.
REQ-012 pause  output  1  mute to the song ROM.
REQ-013 busy  output  1  1 when state is PLAY or PAUSE.
REQ-014 song_done  output  1  one-cycle pulse at end of song.

Function
REQ-015 FSM states IDLE, PLAY, PAUSE; internal divider div_cnt, 32 bits, range 0..BEAT_DIV-1.
REQ-016 Command priority per cycle: stop > play > pause_tgl; lower-priority commands in the same cycle are ignored.
REQ-017 IDLE: beat_num=0, div_cnt=0, en_b=0, pause=0, busy=0; play -> PLAY with beat_num=0, div_cnt=0; pause_tgl and stop have no effect.
REQ-018 PLAY, key_active=0, no command: div_cnt increments; when div_cnt==BEAT_DIV-1 (tick), div_cnt wraps to 0 and beat_num increments by 1.
REQ-019 PLAY, key_active=1: div_cnt and beat_num hold; counting resumes from the held values on the first cycle key_active=0.
REQ-020 Tick with beat_num==LAST_BEAT: beat_num becomes 0; if loop_en=1, stay in PLAY; else go to IDLE. In both cases song_done=1 for exactly the next cycle.
REQ-021 PLAY + pause_tgl -> PAUSE; in that cycle div_cnt and beat_num hold, and any coincident tick is deferred, not lost.
REQ-022 PLAY + play -> restart: beat_num=0, div_cnt=0, stay in PLAY.
REQ-023 PAUSE: div_cnt and beat_num hold; pause_tgl or play -> PLAY, resuming from the held values; stop -> IDLE.
REQ-024 stop in PLAY or PAUSE -> IDLE next cycle with beat_num=0, div_cnt=0; no song_done pulse.
REQ-025 beat_num, busy, en_b and song_done are registered. en_b=1 and busy=1 in PLAY and PAUSE.
REQ-026 pause is combinational: (state==PAUSE) | (state==PLAY & key_active), so key_active mutes in the same cycle.
REQ-027 beat_num never exceeds LAST_BEAT; div_cnt never reaches BEAT_DIV.

Reset
REQ-028 When rst=1 at a clock edge, from any state and mid-beat, the next state is IDLE with beat_num=0, div_cnt=0, en_b=0, pause=0, busy=0, song_done=0. rst overrides all commands.

Verification (BEAT_DIV=4, LAST_BEAT=7)
REQ-029 Reset: assert rst for 2 cycles during PLAY at beat 5 -> the cycle after, all outputs are 0 and state is IDLE.
REQ-030 Single play pulse, loop_en=0 -> beat_num steps 0..7, 4 cycles per beat; after beat 7's tick: beat_num=0, busy=0, song_done high for exactly 1 cycle.
REQ-031 loop_en=1 -> at beat 7's tick, beat_num wraps to 0 with busy held at 1; song_done pulses once per wrap, across 2 full loops.
REQ-032 pause_tgl at beat 3 with div_cnt=2, hold 10 cycles -> beat_num stays 3 and pause=1; second pause_tgl -> beat_num=4 exactly 2 cycles after resume.
REQ-033 key_active high for 6 cycles in PLAY -> pause=1 in the same cycles; beat_num and div_cnt frozen; beat timing resumes unshifted from the frozen point.
REQ-034 Simultaneous events: stop+play in one cycle of PLAY -> IDLE; play+pause_tgl in PLAY -> restart at beat 0, not PAUSE; pause_tgl on a tick cycle -> beat_num does not increment until resume.

Source files
------------

// File: rtl/music_beat_ctrl.sv
// music_beat_ctrl: song sequencer FSM stepping a quarter-beat index with play/pause/stop/loop control
module music_beat_ctrl #(
  parameter logic [31:0] BEAT_DIV = 32'd12_500_000,
  parameter logic [7:0] LAST_BEAT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       pause_tgl,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       key_active,
  output logic [7:0] beat_num,
  output logic       en_b,
  output logic       pause,
  output logic       busy,
  output logic       song_done
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
  state_t state, state_n;
  logic [31:0] div_cnt, div_n;
  logic [7:0] beat_n;
  logic done_n, tick;
  assign tick = div_cnt == BEAT_DIV - 32'd1;
  assign pause = (state == PAUSE) | ((state == PLAY) & key_active);
  // next-state: stop beats play beats pause_tgl; a key press only freezes counting
  always_comb begin
    state_n = state;
    div_n = div_cnt;
    beat_n = beat_num;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        beat_n = '0;
        if (play) state_n = PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
          div_n = '0;
          beat_n = '0;
        end else if (play) begin
          div_n = '0;
          beat_n = '0;
        end else if (pause_tgl) begin
          state_n = PAUSE;
        end else if (!key_active) begin
          div_n = tick ? '0 : div_cnt + 32'd1;
          if (tick && beat_num == LAST_BEAT) begin
            beat_n = '0;
            done_n = 1'b1;
            if (!loop_en) state_n = IDLE;
          end else if (tick) begin
            beat_n = beat_num + 8'd1;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
          div_n = '0;
          beat_n = '0;
        end else if (play || pause_tgl) begin
          state_n = PLAY;
        end
      end
      default: begin
        state_n = IDLE;
        div_n = '0;
        beat_n = '0;
      end
    endcase
  end
  // state and registered outputs; busy/en_b follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= '0;
      beat_num <= '0;
      en_b <= 1'b0;
      busy <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= div_n;
      beat_num <= beat_n;
      en_b <= state_n != IDLE;
      busy <= state_n != IDLE;
      song_done <= done_n;
    end
  end
endmodule

// File: tb/tb_music_beat_ctrl.sv
// tb_music_beat_ctrl: directed and randomized checks of music_beat_ctrl against a song-position model
module tb_music_beat_ctrl;
  localparam int BD = 4;
  localparam int LB = 7;
  localparam int TOTAL = (LB + 1) * BD;
  logic clk = 1'b0;
  logic rst = 1'b0, play = 1'b0, pause_tgl = 1'b0, stop = 1'b0, loop_en = 1'b0, key_active = 1'b0;
  logic [7:0] beat_num;
  logic en_b, pause, busy, song_done;
  int n_cmp = 0, n_fail = 0;
  int m_mode = 0;
  int m_pos = 0;
  bit m_done = 1'b0;
  music_beat_ctrl #(.BEAT_DIV(32'd4), .LAST_BEAT(8'd7)) dut (
    .clk(clk), .rst(rst), .play(play), .pause_tgl(pause_tgl), .stop(stop),
    .loop_en(loop_en), .key_active(key_active), .beat_num(beat_num),
    .en_b(en_b), .pause(pause), .busy(busy), .song_done(song_done)
  );
  always #5 clk = ~clk;
  // one clock with the given inputs; the model tracks mode (0 idle,1 play,2 pause) and position in cycles
  task automatic drive(input bit r, input bit p, input bit t, input bit s, input bit l, input bit k);
    @(negedge clk);
    rst = r; play = p; pause_tgl = t; stop = s; loop_en = l; key_active = k;
    @(posedge clk);
    m_done = 1'b0;
    if (r) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      if (p) m_mode = 1;
      m_pos = 0;
    end else if (s) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 2) begin
      if (p || t) m_mode = 1;
    end else if (p) begin
      m_pos = 0;
    end else if (t) begin
      m_mode = 2;
    end else if (!k) begin
      m_pos++;
      if (m_pos == TOTAL) begin
        m_pos = 0; m_done = 1'b1;
        if (!l) m_mode = 0;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({beat_num, en_b, pause, busy, song_done} !== 12'd0) begin
      n_fail++; $display("FAIL reset_init got %h want 000", {beat_num, en_b, pause, busy, song_done});
    end
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5 * BD; i++) drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre beat=%0d busy=%b want 5 1", beat_num, busy);
    end
    drive(1, 1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({beat_num, en_b, pause, busy, song_done} !== 12'd0) begin
      n_fail++; $display("FAIL reset_mid got %h want 000", {beat_num, en_b, pause, busy, song_done});
    end
  endtask
  task automatic test_single_play();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i < TOTAL; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (beat_num !== 8'(i / BD) || busy !== 1'b1 || en_b !== 1'b1 || song_done !== 1'b0) begin
        n_fail++; $display("FAIL single_step i=%0d beat=%0d busy=%b en=%b done=%b want %0d 1 1 0",
                           i, beat_num, busy, en_b, song_done, i / BD);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd0 || busy !== 1'b0 || en_b !== 1'b0 || song_done !== 1'b1) begin
      n_fail++; $display("FAIL single_end beat=%0d busy=%b en=%b done=%b want 0 0 0 1", beat_num, busy, en_b, song_done);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (song_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done_width done=%b busy=%b want 0 0", song_done, busy);
    end
  endtask
  task automatic test_loop();
    int dones = 0;
    drive(0, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 2 * TOTAL; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      if (song_done) dones++;
      n_cmp++;
      if (beat_num !== 8'((i % TOTAL) / BD) || busy !== 1'b1 || song_done !== (i % TOTAL == 0)) begin
        n_fail++; $display("FAIL loop_step i=%0d beat=%0d busy=%b done=%b want %0d 1 %b",
                           i, beat_num, busy, song_done, (i % TOTAL) / BD, i % TOTAL == 0);
      end
    end
    n_cmp++;
    if (dones != 2) begin
      n_fail++; $display("FAIL loop_done_count got %0d want 2", dones);
    end
    drive(0, 0, 0, 1, 0, 0);
  endtask
  task automatic test_pause();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * BD + 2; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (beat_num !== 8'd3 || pause !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL pause_hold i=%0d beat=%0d pause=%b busy=%b want 3 1 1", i, beat_num, pause, busy);
      end
      drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd3 || pause !== 1'b0) begin
      n_fail++; $display("FAIL pause_resume beat=%0d pause=%b want 3 0", beat_num, pause);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd3) begin
      n_fail++; $display("FAIL pause_resume1 beat=%0d want 3", beat_num);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd4) begin
      n_fail++; $display("FAIL pause_resume2 beat=%0d want 4", beat_num);
    end
    drive(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (busy !== 1'b0 || beat_num !== 8'd0 || song_done !== 1'b0) begin
      n_fail++; $display("FAIL pause_stop busy=%b beat=%0d done=%b want 0 0 0", busy, beat_num, song_done);
    end
  endtask
  task automatic test_key();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_active = 1'b1;
      #1;
      n_cmp++;
      if (pause !== 1'b1) begin
        n_fail++; $display("FAIL key_mute_same_cycle i=%0d pause=%b want 1", i, pause);
      end
      drive(0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (beat_num !== 8'd1 || pause !== 1'b1) begin
        n_fail++; $display("FAIL key_freeze i=%0d beat=%0d pause=%b want 1 1", i, beat_num, pause);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd1 || pause !== 1'b0) begin
      n_fail++; $display("FAIL key_release beat=%0d pause=%b want 1 0", beat_num, pause);
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd2) begin
      n_fail++; $display("FAIL key_unshifted beat=%0d want 2", beat_num);
    end
    drive(0, 0, 0, 1, 0, 0);
  endtask
  task automatic test_simultaneous();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    n_cmp++;
    if (busy !== 1'b0 || beat_num !== 8'd0) begin
      n_fail++; $display("FAIL stop_play busy=%b beat=%0d want 0 0", busy, beat_num);
    end
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    n_cmp++;
    if (busy !== 1'b1 || pause !== 1'b0 || beat_num !== 8'd0) begin
      n_fail++; $display("FAIL play_pause busy=%b pause=%b beat=%0d want 1 0 0", busy, pause, beat_num);
    end
    for (int i = 0; i < BD - 1; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd0 || pause !== 1'b1) begin
      n_fail++; $display("FAIL tick_pause beat=%0d pause=%b want 0 1", beat_num, pause);
    end
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (beat_num !== 8'd1) begin
      n_fail++; $display("FAIL tick_deferred beat=%0d want 1", beat_num);
    end
    drive(0, 0, 0, 1, 0, 0);
  endtask
  task automatic test_random();
    bit r, p, t, s, l, k;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(199) == 0;
      p = $urandom_range(39) == 0;
      t = $urandom_range(19) == 0;
      s = $urandom_range(79) == 0;
      l = $urandom_range(3) != 0;
      k = $urandom_range(7) == 0;
      drive(r, p, t, s, l, k);
      n_cmp++;
      if (beat_num !== 8'(m_pos / BD) || busy !== (m_mode != 0) || en_b !== (m_mode != 0) ||
          song_done !== m_done || pause !== (m_mode == 2 || (m_mode == 1 && k)) || beat_num > 8'(LB)) begin
        n_fail++; $display("FAIL random i=%0d beat=%0d busy=%b en=%b done=%b pause=%b want %0d %b %b %b %b",
                           i, beat_num, busy, en_b, song_done, pause, m_pos / BD, m_mode != 0, m_mode != 0,
                           m_done, m_mode == 2 || (m_mode == 1 && k));
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_play();
    test_loop();
    test_pause();
    test_key();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
